// File: rtl/lut_cfg_pkg.sv
// ============================================================================
// Module  : lut_cfg_pkg
// Brief   : Shared types and helpers for the LUT select-line config loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    localparam int c_n_lut_default = 8;

    // The counter must be able to hold N_LUT itself, not just N_LUT-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_shift_reg.sv
// ============================================================================
// Module  : cfg_shift_reg
// Brief   : Serial-in / parallel-out shadow register for LUT select bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_shift_reg #(
    parameter int N_LUT     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_shift_en,
    input  logic             i_bit,
    output logic [N_LUT-1:0] o_shadow
);

    logic [N_LUT-1:0] r_shadow;
    logic [N_LUT-1:0] w_shifted;

    // Shift direction decides where the first received bit ends up.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shadow[N_LUT-2:0], i_bit};
        end else begin : g_lsb_first
            assign w_shifted = {i_bit, r_shadow[N_LUT-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (i_clear) begin
            r_shadow <= '0;
        end else if (i_shift_en) begin
            r_shadow <= w_shifted;
        end
    end

    assign o_shadow = r_shadow;

endmodule

`default_nettype wire

// File: rtl/lut_cfg_loader.sv
// ============================================================================
// Module  : lut_cfg_loader
// Brief   : Serial valid/ready config loader committing LUT selects atomically.
//           Define LUT_CFG_PARITY_EN to append and check an even-parity bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int N_LUT     = c_n_lut_default,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_bit,
    output logic [N_LUT-1:0] sel_out,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int             CW         = cnt_width(N_LUT);
    localparam logic [CW-1:0]  c_last_idx = CW'(N_LUT - 1);

    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [N_LUT-1:0] r_sel;
    logic [N_LUT-1:0] w_shadow;
    logic             r_err;
    logic             w_ready;
    logic             w_shift_en;
    logic             w_clear;
    logic             w_err_set;
    logic             w_err_clr;

    cfg_shift_reg #(
        .N_LUT     (N_LUT),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_shift_en (w_shift_en),
        .i_bit      (cfg_bit),
        .o_shadow   (w_shadow)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_shift_en  = 1'b0;
        w_clear     = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = SHIFT;
                    w_clear     = 1'b1;
                    w_err_clr   = 1'b1;
                end
            end
            SHIFT: begin
                w_ready = 1'b1;
                // A restart mid-frame aborts, even if it coincides with the last bit.
                if (cfg_start) begin
                    w_state_nxt = IDLE;
                    w_err_set   = 1'b1;
                end else if (cfg_valid) begin
                    w_shift_en = 1'b1;
                    if (r_count == c_last_idx) begin
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
`ifdef LUT_CFG_PARITY_EN
                w_ready = 1'b1;
                if (cfg_valid) begin
                    if ((^w_shadow ^ cfg_bit) == 1'b0) begin
                        w_state_nxt = COMMIT;
                    end else begin
                        w_state_nxt = IDLE;
                        w_err_set   = 1'b1;
                    end
                end
`else
                w_state_nxt = COMMIT;
`endif
            end
            COMMIT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_sel   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_count <= '0;
            end else if (w_shift_en) begin
                r_count <= r_count + CW'(1);
            end
            if (r_state == COMMIT) begin
                r_sel <= w_shadow;
            end
            if (w_err_clr) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cfg_ready = w_ready;
    assign sel_out   = r_sel;
    assign cfg_busy  = (r_state != IDLE);
    assign cfg_done  = (r_state == COMMIT);
    assign cfg_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lut_cfg_loader.sv
// ============================================================================
// Module  : tb_lut_cfg_loader
// Brief   : Randomised self-checking bench for lut_cfg_loader (N_LUT=8, MSB first).
//           Honours LUT_CFG_PARITY_EN when the design is built with it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_cfg_loader;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         cfg_start;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_bit;
    logic [N-1:0] sel_out;
    logic         cfg_busy;
    logic         cfg_done;
    logic         cfg_err;

    int n_total;
    int n_bad;

    // Reference state: what sel_out and cfg_err should be between frames.
    logic [N-1:0] m_sel;
    logic         m_err;

`ifdef LUT_CFG_PARITY_EN
    localparam bit c_par = 1'b1;
`else
    localparam bit c_par = 1'b0;
`endif

    lut_cfg_loader #(.N_LUT(N), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_bit   (cfg_bit),
        .sel_out   (sel_out),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_state(input string tag);
        check_eq({tag, "_sel"},  32'(sel_out),   32'(m_sel));
        check_eq({tag, "_err"},  32'(cfg_err),   32'(m_err));
        check_eq({tag, "_busy"}, 32'(cfg_busy),  32'd0);
        check_eq({tag, "_done"}, 32'(cfg_done),  32'd0);
        check_eq({tag, "_rdy"},  32'(cfg_ready), 32'd0);
    endtask

    // One frame. gap: random valid gaps. bad_par: corrupt the parity bit.
    // abort_at >= 0: pulse cfg_start once that many items have been accepted.
    task automatic do_frame(input logic [N-1:0] val, input bit gap, input bit bad_par,
                            input int abort_at);
        bit q[$];
        int idx;
        int cyc;
        bit drv;
        bit rdy;
        bit expect_commit;
        for (int i = 0; i < N; i++) q.push_back(val[N-1-i]);
        if (c_par) q.push_back((^val) ^ bad_par);
        expect_commit = (abort_at < 0) && !(c_par && bad_par);

        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        m_err = 1'b0;
        check_eq("start_busy", 32'(cfg_busy), 32'd1);
        check_eq("start_err_clr", 32'(cfg_err), 32'd0);

        idx = 0;
        cyc = 0;
        while (idx < q.size() && cyc < 200) begin
            if (idx == abort_at) begin
                cfg_start = 1'b1;
                cfg_valid = 1'b1;
                cfg_bit   = q[idx];
                @(negedge clk);
                cfg_start = 1'b0;
                cfg_valid = 1'b0;
                m_err = 1'b1;
                check_idle_state("abort");
                return;
            end
            drv = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy = cfg_ready;
            cfg_valid = drv;
            cfg_bit   = drv ? q[idx] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (drv && rdy) idx++;
            cyc++;
            check_eq("hold_sel", 32'(sel_out), 32'(m_sel));
            if (idx < q.size()) check_eq("hold_done", 32'(cfg_done), 32'd0);
        end
        if (cyc >= 200) check_eq("frame_timeout", 32'(cyc), 32'd0);
        // Keep offering bits: nothing past the frame may be accepted.
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;

        if (!c_par) begin
            check_eq("check_rdy", 32'(cfg_ready), 32'd0);
            check_eq("check_done", 32'(cfg_done), 32'd0);
            @(negedge clk);
        end
        if (expect_commit) begin
            check_eq("commit_done", 32'(cfg_done), 32'd1);
            check_eq("commit_sel_old", 32'(sel_out), 32'(m_sel));
            @(negedge clk);
            m_sel = val;
            cfg_valid = 1'b0;
            check_idle_state("commit");
        end else begin
            cfg_valid = 1'b0;
            m_err = 1'b1;
            check_idle_state("parity_err");
        end
    endtask

    initial begin
        logic [N-1:0] v;
        n_total   = 0;
        n_bad     = 0;
        m_sel     = '0;
        m_err     = 1'b0;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE with valid held and no start: nothing accepted.
        cfg_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cfg_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check_idle_state("idle_valid");

        do_frame(8'hA5, 1'b0, 1'b0, -1);
        do_frame(8'hA5, 1'b1, 1'b0, -1);
        do_frame(8'h3C, 1'b0, 1'b0, -1);
        do_frame(8'hC3, 1'b0, 1'b0, 4);
        do_frame(8'h5A, 1'b0, 1'b0, N - 1);
        if (c_par) do_frame(8'h3C, 1'b0, 1'b1, -1);

        for (int t = 0; t < 8; t++) begin
            v = N'($urandom);
            do_frame(v, 1'($urandom_range(0, 1)), c_par && ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1);
        end

        // Asynchronous reset part-way through a frame.
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        repeat (3) begin
            cfg_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        m_sel = '0;
        m_err = 1'b0;
        check_eq("rst_mid_sel", 32'(sel_out), 32'd0);
        check_eq("rst_mid_busy", 32'(cfg_busy), 32'd0);
        check_eq("rst_mid_rdy", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_state("post_rst");
        do_frame(8'h96, 1'b1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
